// File: rtl/buffer_pkg.sv
// Shared helpers for the elastic circular buffer family: width math,
// packed-lane slicing and status-flag bit positions for CSR readout.
package buffer_pkg;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Low bit of lane `lane` in a bus of `bits`-wide lanes, lane 0 at the LSBs.
    function automatic int lane_lo(input int lane, input int bits);
        return lane * bits;
    endfunction

    localparam int STAT_OVERFLOW_BIT    = 0;
    localparam int STAT_UNDERFLOW_BIT   = 1;
    localparam int STAT_ALMOST_FULL_BIT = 2;
    localparam int STAT_EMPTY_BIT       = 3;
    localparam int STAT_FULL_BIT        = 4;
    localparam int STAT_W               = 5;

endpackage

// File: rtl/ring_ptr_advance.sv
// Modular pointer adder for rings of arbitrary DEPTH; n must not exceed DEPTH,
// so a single conditional subtract is enough to wrap.
module ring_ptr_advance #(
    parameter int DEPTH = 60,
    parameter int PW    = 6,
    parameter int NW    = 1
) (
    input  logic [PW-1:0] ptr,
    input  logic [NW-1:0] n,
    output logic [PW-1:0] next_ptr
);

    localparam int SW = ((PW > NW) ? PW : NW) + 1;

    logic [SW-1:0] sum;

    always_comb begin
        sum = SW'(ptr) + SW'(n);
        if (sum >= SW'(DEPTH)) begin
            sum = sum - SW'(DEPTH);
        end
        next_ptr = PW'(sum);
    end

endmodule

// File: rtl/elastic_circular_buffer.sv
// Multi-word-per-cycle FIFO with show-ahead lane output, occupancy,
// almost-full, synchronous flush and sticky overflow/underflow flags.
module elastic_circular_buffer
    import buffer_pkg::*;
#(
    parameter int BITS      = 22,
    parameter int DEPTH     = 60,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1,
    parameter int AF_LEVEL  = DEPTH - PAR_WRITE,
    parameter int CW        = clog2(DEPTH + 1),
    parameter int WNW       = clog2(PAR_WRITE + 1),
    parameter int RNW       = clog2(PAR_READ + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write_en,
    input  logic [WNW-1:0]            wr_num,
    input  logic [PAR_WRITE*BITS-1:0] din,
    input  logic                      read_en,
    input  logic [RNW-1:0]            rd_num,
    output logic [PAR_READ*BITS-1:0]  dout,
    output logic [PAR_READ-1:0]       lane_valid,
    output logic                      valid,
    output logic                      ready,
    input  logic                      flush,
    output logic [CW-1:0]             count,
    output logic                      almost_full,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   head_adv, tail_adv;
    logic [CW-1:0]   count_q, count_d, free;
    logic            overflow_q, overflow_d, underflow_q, underflow_d;
    logic            wr_ok, rd_ok, wr_acc, rd_acc;
    logic [PAR_WRITE-1:0]         wr_lane_en;
    logic [PAR_WRITE-1:0][PW-1:0] wr_addr;
    logic [PAR_READ-1:0][PW-1:0]  rd_addr;
    logic [BITS-1:0] mem_q [DEPTH];

    assign free = CW'(DEPTH) - count_q;

    ring_ptr_advance #(.DEPTH(DEPTH), .PW(PW), .NW(RNW)) u_head_adv (
        .ptr(head_q), .n(rd_num), .next_ptr(head_adv)
    );

    ring_ptr_advance #(.DEPTH(DEPTH), .PW(PW), .NW(WNW)) u_tail_adv (
        .ptr(tail_q), .n(wr_num), .next_ptr(tail_adv)
    );

    for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wr_lane
        ring_ptr_advance #(.DEPTH(DEPTH), .PW(PW), .NW(WNW)) u_wr_addr (
            .ptr(tail_q), .n(WNW'(k)), .next_ptr(wr_addr[k])
        );
    end

    for (genvar i = 0; i < PAR_READ; i++) begin : g_rd_lane
        ring_ptr_advance #(.DEPTH(DEPTH), .PW(PW), .NW(RNW)) u_rd_addr (
            .ptr(head_q), .n(RNW'(i)), .next_ptr(rd_addr[i])
        );
        assign lane_valid[i]           = count_q > CW'(i);
        assign dout[i*BITS +: BITS]    = lane_valid[i] ? mem_q[rd_addr[i]] : '0;
    end

    // Both sides judge against the pre-cycle count: space freed by a read is
    // not reusable this cycle, and a word written this cycle cannot be retired.
    always_comb begin
        wr_ok       = (int'(wr_num) <= PAR_WRITE) && (int'(wr_num) <= int'(free));
        rd_ok       = int'(rd_num) <= int'(count_q);
        wr_acc      = write_en && wr_ok && !flush;
        rd_acc      = read_en && rd_ok && !flush;
        head_d      = rd_acc ? head_adv : head_q;
        tail_d      = wr_acc ? tail_adv : tail_q;
        count_d     = count_q + (wr_acc ? CW'(wr_num) : '0) - (rd_acc ? CW'(rd_num) : '0);
        overflow_d  = overflow_q | (write_en && !wr_ok);
        underflow_d = underflow_q | (read_en && !rd_ok);
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < PAR_WRITE; k++) begin
            wr_lane_en[k] = wr_acc && (k < int'(wr_num));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PAR_WRITE; k++) begin
            if (wr_lane_en[k]) begin
                mem_q[wr_addr[k]] <= din[lane_lo(k, BITS) +: BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count       = count_q;
    assign valid       = count_q >= CW'(PAR_READ);
    assign ready       = free >= CW'(PAR_WRITE);
    assign almost_full = count_q >= CW'(AF_LEVEL);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_elastic_circular_buffer.sv
// Randomised bench for elastic_circular_buffer against a queue-based model,
// with directed literal expectations that pin the model.
module tb_elastic_circular_buffer;

    localparam int BITS = 22;
    localparam int DEPTH = 6;
    localparam int PWR = 3;
    localparam int PRD = 2;
    localparam int AF = 5;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic write_en = 1'b0, read_en = 1'b0, flush = 1'b0;
    logic [1:0] wr_num = '0, rd_num = '0;
    logic [PWR*BITS-1:0] din = '0;
    logic [PRD*BITS-1:0] dout;
    logic [PRD-1:0] lane_valid;
    logic valid, ready, almost_full, overflow, underflow;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [BITS-1:0] q[$];
    bit m_ovf = 1'b0, m_udf = 1'b0;

    always #5 clk = ~clk;

    elastic_circular_buffer #(
        .BITS(BITS), .DEPTH(DEPTH), .PAR_WRITE(PWR), .PAR_READ(PRD), .AF_LEVEL(AF)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .wr_num(wr_num), .din(din),
        .read_en(read_en), .rd_num(rd_num), .dout(dout), .lane_valid(lane_valid),
        .valid(valid), .ready(ready), .flush(flush), .count(count),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue semantics: both requests judged on the occupancy before the edge.
    task automatic model_step();
        int n0;
        n0 = q.size();
        if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (read_en) begin
                if (int'(rd_num) <= n0) begin
                    for (int k = 0; k < int'(rd_num); k++) void'(q.pop_front());
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (write_en) begin
                if (int'(wr_num) <= PWR && int'(wr_num) <= DEPTH - n0) begin
                    for (int k = 0; k < int'(wr_num); k++) q.push_back(din[k*BITS +: BITS]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit we, input int wn, input logic [BITS-1:0] d0, d1, d2,
                       input bit re, input int rn, input bit fl);
        write_en = we;
        wr_num   = 2'(wn);
        din      = {d2, d1, d0};
        read_en  = re;
        rd_num   = 2'(rn);
        flush    = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [BITS-1:0] e;
            chk("count", 64'(count), 64'(q.size()));
            for (int i = 0; i < PRD; i++) begin
                e = '0;
                if (q.size() > i) e = q[i];
                chk("lane_valid", 64'(lane_valid[i]), 64'(q.size() > i));
                chk("dout_lane", 64'(dout[i*BITS +: BITS]), 64'(e));
            end
            chk("valid", 64'(valid), 64'(q.size() >= PRD));
            chk("ready", 64'(ready), 64'(DEPTH - q.size() >= PWR));
            chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("underflow", 64'(underflow), 64'(m_udf));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 0);
        chk("rst_ready", 64'(ready), 1);
        chk("rst_valid", 64'(valid), 0);
        chk("rst_lane_valid", 64'(lane_valid), 0);
        chk("rst_dout", 64'(dout), 0);
        chk("rst_flags", 64'({overflow, underflow, almost_full}), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        cyc(1, 3, 10, 11, 12, 0, 0, 0);
        chk("first_count", 64'(count), 3);
        chk("first_valid", 64'(valid), 1);
        chk("first_lane0", 64'(dout[BITS-1:0]), 10);
        chk("first_lane1", 64'(dout[2*BITS-1:BITS]), 11);

        cyc(1, 3, 13, 14, 15, 0, 0, 0);
        chk("full_count", 64'(count), 6);
        chk("full_ready", 64'(ready), 0);
        chk("full_af", 64'(almost_full), 1);

        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("rd_count", 64'(count), 4);
        chk("rd_lane0", 64'(dout[BITS-1:0]), 12);
        chk("rd_lane1", 64'(dout[2*BITS-1:BITS]), 13);

        cyc(1, 2, 16, 17, 0, 0, 0, 0);
        chk("wrap_count", 64'(count), 6);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("drain1", 64'(dout), {22'd15, 22'd14});
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("drain2", 64'(dout), {22'd17, 22'd16});
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("drain_count", 64'(count), 0);
        chk("drain_dout", 64'(dout), 0);

        cyc(1, 3, 20, 21, 22, 0, 0, 0);
        cyc(1, 3, 23, 24, 25, 1, 2, 0);
        chk("simul_count", 64'(count), 4);
        chk("simul_lane0", 64'(dout[BITS-1:0]), 22);

        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        cyc(1, 3, 26, 27, 28, 0, 0, 0);
        chk("pre_ovf_count", 64'(count), 5);
        cyc(1, 3, 30, 31, 32, 0, 0, 0);
        chk("ovf_count", 64'(count), 5);
        chk("ovf_flag", 64'(overflow), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 64'(overflow), 1);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("pre_udf_count", 64'(count), 1);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        chk("udf_count", 64'(count), 1);
        chk("udf_flag", 64'(underflow), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_count", 64'(count), 0);
        chk("flush_flags", 64'({overflow, underflow}), 0);

        cyc(1, 3, 40, 41, 42, 0, 0, 0);
        cyc(1, 3, 43, 44, 45, 0, 0, 1);
        chk("flush_ovr_count", 64'(count), 0);
        chk("flush_ovr_valid", 64'(valid), 0);

        cyc(1, 3, 50, 51, 52, 0, 0, 0);
        cyc(1, 1, 53, 0, 0, 0, 0, 0);
        chk("pre_rst_count", 64'(count), 4);
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 0);
        chk("async_rst_lanes", 64'(lane_valid), 0);
        chk("async_rst_ready", 64'(ready), 1);
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        repeat (3000) begin
            cyc(($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)),
                BITS'($urandom), BITS'($urandom), BITS'($urandom),
                ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)),
                ($urandom_range(0, 39) == 0));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elastic_circular_buffer.md
Name: elastic_circular_buffer

Overview:
- Next-generation PE-side FIFO (IFMap, Filter, input Psum, output Psum queues).
- Each cycle it accepts a variable number of words, 0..PAR_WRITE, and retires a variable number, 0..PAR_READ.
- The oldest words are shown show-ahead on a packed lane bus, with per-lane valid bits.
- Adds occupancy, almost-full, synchronous flush and sticky overflow/underflow flags, and supports non-power-of-2 DEPTH.

Parameters:
- BITS, 22: word width (IFMap word = data + 2 tag bits).
- DEPTH, 60: storage words; any value ≥ max(PAR_WRITE, PAR_READ).
- PAR_WRITE, 1: max words written per cycle.
- PAR_READ, 1: max words retired per cycle; also number of dout lanes.
- AF_LEVEL, DEPTH-PAR_WRITE: almost_full threshold.
- CW, $clog2(DEPTH+1): count width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- write_en  in  1  write request.
- wr_num  in  $clog2(PAR_WRITE+1)  words to write this cycle.
- din  in  PAR_WRITE*BITS  lane 0 = LSBs = first word written.
- read_en  in  1  retire request.
- rd_num  in  $clog2(PAR_READ+1)  words to retire this cycle.
- dout  out  PAR_READ*BITS  lane i = (i+1)-th oldest word.
- lane_valid  out  PAR_READ  lane_valid[i] = count > i.
- valid  out  1  count ≥ PAR_READ (legacy compatible).
- ready  out  1  DEPTH-count ≥ PAR_WRITE (legacy compatible).
- flush  in  1  synchronous clear.
- count  out  CW  current occupancy.
- almost_full  out  1  count ≥ AF_LEVEL.
- overflow  out  1  sticky: rejected write.
- underflow  out  1  sticky: rejected read.

Behaviour:
- **State:** registers head, tail (0..DEPTH-1), count, overflow, underflow. Memory array is not reset.
- **Reset (rst=0, asynchronous):**
  - head = tail = count = 0; overflow = underflow = 0.
  - Outputs: ready=1, valid=0, lane_valid=0, almost_full=0 (when AF_LEVEL>0), dout=0.
  - Takes effect without a clock edge; a reset mid-transfer discards all contents.
- **Outputs are combinational from registers only** (no input-to-output paths):
  - dout lane i = mem[(head+i) mod DEPTH] when lane_valid[i], else 0.
- **Write acceptance:**
  - Accepted iff write_en && wr_num ≤ DEPTH − count, evaluated on the pre-cycle count.
  - No same-cycle reuse of space freed by a read.
  - On accept: din lanes 0..wr_num-1 go to mem[(tail+k) mod DEPTH]; tail advances by wr_num modulo DEPTH.
  - wr_num=0 is a no-op; wr_num > PAR_WRITE is treated as rejected.
- **Read acceptance:**
  - Accepted iff read_en && rd_num ≤ count, pre-cycle count.
  - No write-through: a word written this cycle is visible from the next cycle.
  - On accept: head advances by rd_num modulo DEPTH.
- **Rejection:** a rejected write or read leaves pointers and count unchanged and sets overflow or underflow respectively. The flag holds until flush or reset.
- **Count update:** count_next = count + wr_acc − rd_acc. Simultaneous write and read are both evaluated independently against the old count.
- **Wrap:** pointer advance is ptr+n; if ≥ DEPTH, subtract DEPTH. No power-of-2 masking.
- **Flush (sampled at the clock edge):**
  - head = tail = count = 0 and both flags cleared.
  - Overrides any write or read in the same cycle; the data of that cycle is dropped.
- **Latency:** a write on edge N is visible on dout after edge N. A retire on edge N exposes the next words after edge N.
- **Full/empty:** full ⇔ count==DEPTH (ready=0); empty ⇔ count==0 (all lane_valid=0, dout=0).

Decomposition:
- **Shared package buffer_pkg:**
  - clog2 helper function.
  - Lane slice macro/function for packed buses.
  - Status flag bit positions, for future CSR readout.
- **Sub-module ring_ptr_advance:**
  - Combinational modular adder (ptr, n, DEPTH) → next_ptr.
  - Instantiated for head, for tail, and per lane for read addresses.

Test Plan (DEPTH=6, PAR_WRITE=3, PAR_READ=2, BITS=22, AF_LEVEL=5):
- **Reset:** hold rst=0 for 2 cycles → count=0, ready=1, valid=0, lane_valid=00, dout=0, flags=0.
- **First write:** write_en, wr_num=3, din={12,11,10} → next cycle count=3, valid=1, dout lanes = 10,11.
- **Fill and wrap:**
  - Write 13,14,15 → count=6, ready=0, almost_full=1.
  - Read rd_num=2 → count=4, dout = 12,13.
  - Write wr_num=2 {17,16} → stored at addresses 0,1.
  - Drain with rd_num=2 → words emerge in order 12..17, final count=0.
- **Simultaneous:** at count=3, write 3 and read 2 in the same cycle → count=4, oldest lane = third word.
- **Rejects:**
  - At count=5, wr_num=3 → rejected, count=5, overflow=1 sticky.
  - At count=1, rd_num=2 → rejected, underflow=1.
  - Flush → both flags cleared, count=0.
- **Flush/reset override:**
  - flush with concurrent wr_num=3 → count=0, valid=0.
  - rst asserted between clock edges while count=4 → count=0 immediately, before the next edge.
